// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: byte-serial imem reads assembled into big-endian
// words, buffered with their PCs in a show-ahead FIFO, flushed on redirect.
//   state    | meaning
//   FETCH    | issuing byte requests
//   FULL     | issue rule false, waiting for a pop
//   FLUSH    | cycle after a redirect, no request issued
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_FETCH, ST_FULL, ST_FLUSH} state_e;

   state_e             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [1:0]         issue_idx_q, issue_idx_d;
   logic               wia_q, wia_d;
   logic [31:0]        asm_pc_q, asm_pc_d;
   logic [23:0]        asm_data_q, asm_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic [1:0]         rx_idx_q, rx_idx_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        word_mem_q [DEPTH];
   logic [31:0]        pc_mem_q   [DEPTH];

   logic [CNT_W-1:0]   occ;
   logic               issue_ok;
   logic               rx_take;
   logic               push;
   logic               pop;
   logic               unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc[1:0];

   // Once byte 0 of a word has issued, the remaining bytes always follow;
   // the occupancy rule only gates the start of a new word.
   assign occ      = count_q + {{PTR_W{1'b0}}, wia_q};
   assign issue_ok = (issue_idx_q != 2'd0) || (occ < CNT_W'(DEPTH));
   assign imem_req = rst_n && !redirect && (state_q == ST_FETCH) && issue_ok;
   assign imem_addr = imem_req ? (fetch_pc_q[ADDR_W-1:0] + ADDR_W'(issue_idx_q)) : '0;

   assign rx_take    = rx_valid_q && !redirect && (state_q != ST_FLUSH);
   assign push       = rx_take && (rx_idx_q == 2'd3);
   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid && inst_ready && !redirect;
   assign inst       = inst_valid ? word_mem_q[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      issue_idx_d = issue_idx_q;
      wia_d       = wia_q;
      asm_pc_d    = asm_pc_q;
      asm_data_d  = asm_data_q;
      rx_valid_d  = imem_req;
      rx_idx_d    = issue_idx_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      case (state_q)
         ST_FETCH: if (!issue_ok) state_d = ST_FULL;
         ST_FULL:  if (issue_ok) state_d = ST_FETCH;
         ST_FLUSH: state_d = ST_FETCH;
         default:  state_d = ST_FETCH;
      endcase

      if (redirect) begin
         state_d     = ST_FLUSH;
         fetch_pc_d  = {redirect_pc[31:2], 2'b00};
         issue_idx_d = 2'd0;
         wia_d       = 1'b0;
         rx_valid_d  = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end else begin
         if (push) wia_d = 1'b0;
         if (imem_req) begin
            issue_idx_d = issue_idx_q + 2'd1;
            if (issue_idx_q == 2'd0) begin
               wia_d    = 1'b1;
               asm_pc_d = fetch_pc_q;
            end
            if (issue_idx_q == 2'd3) fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rx_take) begin
            case (rx_idx_q)
               2'd0:    asm_data_d[23:16] = imem_rdata;
               2'd1:    asm_data_d[15:8]  = imem_rdata;
               2'd2:    asm_data_d[7:0]   = imem_rdata;
               default: asm_data_d        = asm_data_q;
            endcase
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         fetch_pc_q  <= RESET_PC;
         issue_idx_q <= 2'd0;
         wia_q       <= 1'b0;
         asm_pc_q    <= '0;
         asm_data_q  <= '0;
         rx_valid_q  <= 1'b0;
         rx_idx_q    <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         issue_idx_q <= issue_idx_d;
         wia_q       <= wia_d;
         asm_pc_q    <= asm_pc_d;
         asm_data_q  <= asm_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_idx_q    <= rx_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         word_mem_q[wr_ptr_q] <= {asm_data_q, imem_rdata};
         pc_mem_q[wr_ptr_q]   <= asm_pc_q;
      end
   end

endmodule
